// File: rtl/cgra_route_pkg.sv
// Shared definitions for the CGRA edge loader and router.
// Holds the grid sizing, the packed edge format {src, dst}, the loader
// state encoding and the router orientation codes.
package cgra_route_pkg;

    localparam int GRID_SIZE = 4;
    localparam int NUM_PE    = GRID_SIZE * GRID_SIZE;
    localparam int MAX_EDGES = 11;
    localparam int PE_W      = 4;
    localparam int CNT_W     = 4;

    // Table depth as a count-width constant so address compares stay 4 bits wide.
    localparam logic [CNT_W-1:0] MAX_EDGES_C = CNT_W'(MAX_EDGES);

    // Router format: bits [7:4] = src, bits [3:0] = dst.
    typedef struct packed {
        logic [3:0] src;
        logic [3:0] dst;
    } edge_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SCAN,
        COMMIT,
        DONE
    } load_state_t;

    localparam logic [1:0] DIR_RIGHT = 2'd3;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_TOP   = 2'd1;
    localparam logic [1:0] DIR_BOT   = 2'd0;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/edge_table_ram.sv
// MAX_EDGES x 8 edge table.
//   clk, reset          : clock, synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data : single synchronous write port (CLEAR and COMMIT)
//   cmp_addr -> cmp_data  : combinational read used for duplicate scanning
//   rd_addr  -> rd_data   : registered router read, 1-cycle latency, 0 when out of range
module edge_table_ram
    import cgra_route_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  edge_t      wr_data,
    input  logic [3:0] cmp_addr,
    output edge_t      cmp_data,
    input  logic [3:0] rd_addr,
    output edge_t      rd_data
);

    edge_t mem [MAX_EDGES];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < MAX_EDGES_C)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign cmp_data = (cmp_addr < MAX_EDGES_C) ? mem[cmp_addr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= (rd_addr < MAX_EDGES_C) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/edge_list_loader.sv
// Streams DFG edges into the router's edge table, rejecting self-loops,
// duplicates and overflow, and builds the PE-usage map.
//   clk, reset                       : clock, synchronous active-high reset
//   start                            : pulse, clear tables and (re)start a load
//   in_valid/in_ready/in_src/in_dst/in_last : edge stream handshake
//   rd_addr -> rd_edge               : registered table read for the router
//   edge_count, pe_used, load_done   : load results
//   err_selfloop, err_overflow, dup_count : sticky error status
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | zeroing one table entry per cycle
// LOAD   | accepting edge words (in_ready high)
// SCAN   | comparing captured edge against stored edges, one per cycle
// COMMIT | writing captured edge into the table
// DONE   | table valid, load_done held
module edge_list_loader
    import cgra_route_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PE_W-1:0]   in_src,
    input  logic [PE_W-1:0]   in_dst,
    input  logic              in_last,
    input  logic [3:0]        rd_addr,
    output logic [7:0]        rd_edge,
    output logic [CNT_W-1:0]  edge_count,
    output logic [NUM_PE-1:0] pe_used,
    output logic              load_done,
    output logic              err_selfloop,
    output logic              err_overflow,
    output logic [3:0]        dup_count
);

    load_state_t      state;
    logic [3:0]       clr_idx;
    logic [3:0]       scan_idx;
    edge_t            cap;
    logic             cap_last;

    logic             wr_en;
    logic [3:0]       wr_addr;
    edge_t            wr_data;
    edge_t            cmp_data;
    edge_t            rd_word;

    // CLEAR and COMMIT share the single write port; they are never active together.
    assign wr_en   = (state == CLEAR) || (state == COMMIT);
    assign wr_addr = (state == CLEAR) ? clr_idx : edge_count;
    assign wr_data = (state == CLEAR) ? edge_t'('0) : cap;

    assign in_ready = (state == LOAD);
    assign rd_edge  = rd_word;

    edge_table_ram u_table (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cmp_addr (scan_idx),
        .cmp_data (cmp_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            clr_idx      <= '0;
            scan_idx     <= '0;
            cap          <= '0;
            cap_last     <= 1'b0;
            edge_count   <= '0;
            pe_used      <= '0;
            load_done    <= 1'b0;
            err_selfloop <= 1'b0;
            err_overflow <= 1'b0;
            dup_count    <= '0;
        end else if (start) begin
            // Start wins in every state: a pending captured edge is simply abandoned.
            state        <= CLEAR;
            clr_idx      <= '0;
            edge_count   <= '0;
            pe_used      <= '0;
            load_done    <= 1'b0;
            err_selfloop <= 1'b0;
            err_overflow <= 1'b0;
            dup_count    <= '0;
        end else begin
            case (state)
                IDLE: ;
                CLEAR: begin
                    if (clr_idx == MAX_EDGES_C - 4'd1) begin
                        state <= LOAD;
                    end else begin
                        clr_idx <= clr_idx + 4'd1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        cap      <= '{src: in_src, dst: in_dst};
                        cap_last <= in_last;
                        if (in_src == in_dst) begin
                            err_selfloop <= 1'b1;
                            state        <= in_last ? DONE : LOAD;
                            load_done    <= in_last;
                        end else if (edge_count == MAX_EDGES_C) begin
                            err_overflow <= 1'b1;
                            state        <= in_last ? DONE : LOAD;
                            load_done    <= in_last;
                        end else if (edge_count == '0) begin
                            state <= COMMIT;
                        end else begin
                            scan_idx <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (cmp_data == cap) begin
                        dup_count <= sat_inc4(dup_count);
                        state     <= cap_last ? DONE : LOAD;
                        load_done <= cap_last;
                    end else if (scan_idx == edge_count - 4'd1) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
                COMMIT: begin
                    edge_count       <= edge_count + 4'd1;
                    pe_used[cap.src] <= 1'b1;
                    pe_used[cap.dst] <= 1'b1;
                    state            <= cap_last ? DONE : LOAD;
                    load_done        <= cap_last;
                end
                DONE: load_done <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_list_loader.sv
// Self-checking bench for edge_list_loader. A behavioural model tracks the
// accepted edge list; table read-backs push expected words into a queue and
// pop them when the registered read data appears.
module tb_edge_list_loader;
    import cgra_route_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last;
    logic [3:0]  in_src, in_dst, rd_addr;
    logic        in_ready, load_done, err_selfloop, err_overflow;
    logic [7:0]  rd_edge;
    logic [3:0]  edge_count, dup_count;
    logic [15:0] pe_used;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_tab [0:10];
    int          m_cnt;
    logic [15:0] m_pe;
    logic        m_self, m_ovf;
    int          m_dup;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    edge_list_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_src       (in_src),
        .in_dst       (in_dst),
        .in_last      (in_last),
        .rd_addr      (rd_addr),
        .rd_edge      (rd_edge),
        .edge_count   (edge_count),
        .pe_used      (pe_used),
        .load_done    (load_done),
        .err_selfloop (err_selfloop),
        .err_overflow (err_overflow),
        .dup_count    (dup_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_pe   = '0;
        m_self = 1'b0;
        m_ovf  = 1'b0;
        m_dup  = 0;
    endtask

    task automatic model_push(input logic [3:0] s, input logic [3:0] d);
        bit found;
        found = 1'b0;
        if (s == d) begin
            m_self = 1'b1;
        end else if (m_cnt == 11) begin
            m_ovf = 1'b1;
        end else begin
            for (int i = 0; i < m_cnt; i++)
                if (m_tab[i] == {s, d}) found = 1'b1;
            if (found) begin
                if (m_dup < 15) m_dup++;
            end else begin
                m_tab[m_cnt] = {s, d};
                m_cnt++;
                m_pe[s] = 1'b1;
                m_pe[d] = 1'b1;
            end
        end
    endtask

    // Pulse start and count the cycles in_ready stays low (the CLEAR phase).
    task automatic pulse_start(output int clr_cycles);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_reset();
        clr_cycles = 0;
        while (!in_ready && clr_cycles < 50) begin
            clr_cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_edge(input logic [3:0] s, input logic [3:0] d, input logic l,
                             output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_src   = s;
        in_dst   = d;
        in_last  = l;
        while (!in_ready && waits < 200) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!in_ready) begin
            check_val("in_ready_timeout", in_ready, 1);
        end else begin
            @(posedge clk); #1;
            model_push(s, d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!load_done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("load_done", load_done, 1);
    endtask

    task automatic check_results();
        logic [7:0] e;
        check_val("edge_count", edge_count, m_cnt);
        check_val("pe_used", pe_used, m_pe);
        check_val("err_selfloop", err_selfloop, m_self);
        check_val("err_overflow", err_overflow, m_ovf);
        check_val("dup_count", dup_count, m_dup);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            exp_q.push_back((a < m_cnt) ? m_tab[a] : 8'h00);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            check_val($sformatf("rd_edge[%0d]", a), rd_edge, e);
        end
        rd_addr = '0;
    endtask

    initial begin
        int w, c;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_src   = '0;
        in_dst   = '0;
        rd_addr  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_rd_edge", rd_edge, 0);
        check_val("rst_edge_count", edge_count, 0);
        check_val("rst_pe_used", pe_used, 0);
        check_val("rst_load_done", load_done, 0);
        check_val("rst_errs", {err_selfloop, err_overflow}, 0);
        check_val("rst_dup", dup_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic three-edge load.
        pulse_start(c);
        check_val("clear_cycles", c, 11);
        send_edge(4'd0, 4'd5, 1'b0, w);
        send_edge(4'd5, 4'd10, 1'b0, w);
        send_edge(4'd3, 4'd12, 1'b1, w);
        wait_done(c);
        check_val("pe_map_t1", pe_used, 16'h1429);
        check_results();

        // Self-loop dropped.
        pulse_start(c);
        send_edge(4'd2, 4'd2, 1'b0, w);
        send_edge(4'd1, 4'd4, 1'b1, w);
        wait_done(c);
        check_results();

        // Duplicate dropped; scan timing.
        pulse_start(c);
        send_edge(4'd1, 4'd2, 1'b0, w);
        send_edge(4'd1, 4'd2, 1'b0, w);
        send_edge(4'd2, 4'd1, 1'b1, w);
        check_val("scan_stall_dup", w, 1);
        wait_done(c);
        check_val("scan_commit_cycles", c, 2);
        check_results();

        // Overflow on the 12th edge.
        pulse_start(c);
        for (int i = 0; i < 12; i++)
            send_edge(4'(i), 4'(i + 1), (i == 11), w);
        wait_done(c);
        check_val("pe_map_t4", pe_used, 16'h0FFF);
        check_results();

        // Abort in SCAN, then reload.
        pulse_start(c);
        send_edge(4'd0, 4'd1, 1'b0, w);
        send_edge(4'd2, 4'd3, 1'b0, w);
        send_edge(4'd4, 4'd5, 1'b0, w);
        send_edge(4'd6, 4'd9, 1'b0, w);
        pulse_start(c);
        check_val("abort_clear_cycles", c, 11);
        check_val("abort_edge_count", edge_count, 0);
        send_edge(4'd7, 4'd8, 1'b1, w);
        wait_done(c);
        check_val("pe_map_t5", pe_used, 16'h0180);
        check_results();

        // Reset mid-LOAD with a word on the bus.
        pulse_start(c);
        send_edge(4'd4, 4'd9, 1'b0, w);
        in_valid = 1'b1;
        in_src   = 4'd6;
        in_dst   = 4'd7;
        reset    = 1'b1;
        @(posedge clk); #1;
        check_val("mid_rst_in_ready", in_ready, 0);
        check_val("mid_rst_load_done", load_done, 0);
        check_val("mid_rst_edge_count", edge_count, 0);
        check_val("mid_rst_pe_used", pe_used, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_ignores_valid", in_ready, 0);
        check_val("idle_edge_count", edge_count, 0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_list_loader.md
Name: edge_list_loader

Overview:
- Front-end stage that feeds the CGRA edge router.
- Accepts a stream of DFG edges {src PE, dst PE} over a valid/ready handshake, then validates each edge: self-loops, duplicates and overflow.
- Stores accepted edges in a packed edge table and builds a PE-usage map; the router reads both once load_done is high.
- Replaces file-based loading of edge/PE tables with a synthesizable stream interface.

Parameters:
- GRID_SIZE, 4, PEs per grid row/column.
- NUM_PE, 16, total PEs (GRID_SIZE*GRID_SIZE).
- MAX_EDGES, 11, edge table depth.
- PE_W, 4, PE index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse: clear tables and begin a new load.
- in_valid  in  1  edge word valid.
- in_ready  out  1  loader can accept the edge word this cycle.
- in_src  in  PE_W  source PE index.
- in_dst  in  PE_W  destination PE index.
- in_last  in  1  marks the final edge of the list.
- rd_addr  in  4  edge table read index.
- rd_edge  out  8  {src,dst} at rd_addr, registered, 1-cycle latency.
- edge_count  out  4  number of accepted edges.
- pe_used  out  NUM_PE  bit i set if PE i is the src or dst of any accepted edge.
- load_done  out  1  level: table valid for the router.
- err_selfloop  out  1  sticky: an edge with src==dst was seen.
- err_overflow  out  1  sticky: an edge arrived while the table was full.
- dup_count  out  4  duplicate edges dropped, saturating at 15.

Behaviour:
- Reset: state IDLE. All of the following are 0: in_ready, rd_edge, edge_count, pe_used, load_done, err flags, dup_count. Table contents are don't-care.
- Handshake: a transfer occurs when in_valid && in_ready. in_ready is high only in state LOAD. Upstream holds its data stable while in_valid is high and in_ready is low.
- IDLE: start -> CLEAR. All other inputs are ignored.
- CLEAR:
  - Takes MAX_EDGES cycles. Zeroes one table entry per cycle via clr_idx.
  - In the first CLEAR cycle, zero edge_count, pe_used, err flags, dup_count and load_done.
  - After the last entry -> LOAD.
- LOAD: on a transfer, latch {src,dst,last} into a capture register.
  - src==dst: set err_selfloop, drop the edge. last ? DONE : stay in LOAD.
  - edge_count==MAX_EDGES: set err_overflow, drop the edge. last ? DONE : stay in LOAD.
  - edge_count==0: go to COMMIT.
  - Otherwise: set scan_idx=0 and go to SCAN.
- SCAN:
  - One table compare per cycle; in_ready stays low.
  - On a match of both src and dst: increment dup_count (saturating), drop the edge. last ? DONE : LOAD.
  - scan_idx==edge_count-1 with no match: go to COMMIT.
  - Latency is edge_count cycles.
- COMMIT (1 cycle):
  - Write table[edge_count] <= {src,dst}.
  - edge_count+1.
  - pe_used[src] and pe_used[dst] <= 1.
  - last ? DONE : LOAD.
- DONE: load_done=1, held. start -> CLEAR, which clears load_done in the same edge.
- start during CLEAR, LOAD or SCAN: abort the current load and restart CLEAR from index 0. Any edge in the capture register is discarded.
- reset mid-operation: return to IDLE with all outputs per the reset values.
- rd_edge: registered read of table[rd_addr] every cycle, in any state. rd_addr >= MAX_EDGES returns 0.
- Edge packing matches the router's format: bits [7:4] = src (current position), bits [3:0] = dst.
- No range check on indices: NUM_PE = 2^PE_W, so every index is legal.

Decomposition:
- Package cgra_route_pkg holds:
  - GRID_SIZE, NUM_PE, MAX_EDGES, PE_W.
  - typedef edge_t packed struct {logic [3:0] src; logic [3:0] dst;}.
  - Loader state enum: IDLE, CLEAR, LOAD, SCAN, COMMIT, DONE.
  - Orientation constants (right=3, left=2, top=1, bot=0), shared with the router.
- One sub-module: edge_table_ram, MAX_EDGES x 8.
  - One synchronous write port, shared by COMMIT and CLEAR.
  - One combinational compare-read port for SCAN.
  - One registered read port for the router.

Test Plan:
- reset, start, then send edges (0,5),(5,10),(3,12) with last on the third -> edge_count=3; pe_used=16'h1429 (bits 0,3,5,10,12); load_done=1; rd_addr=1 returns 8'h5A one cycle later.
- start, then send (2,2) and (1,4) with last on (1,4) -> err_selfloop=1; edge_count=1; table[0]=8'h14.
- start, then send (1,2),(1,2),(2,1) with last on (2,1) -> dup_count=1; edge_count=2; in_ready is low for exactly 1 cycle while scanning the 2nd edge and 1 cycle for the 3rd.
- start, then send 12 distinct edges with last on the 12th -> edge_count=11; err_overflow=1; 12th edge absent from the table.
- start, 3 edges, then start asserted in SCAN, then 1 edge (7,8) with last -> edge_count=1; pe_used=16'h0180; CLEAR lasts 11 cycles with in_ready low.
- reset asserted mid-LOAD with in_valid high -> next cycle in_ready=0, load_done=0, edge_count=0.
